// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : melody_pkg
//  Description : Shared definitions for the melody sequencer: note indices,
//                song ids and base addresses, ROM entry layout, FSM state
//                encodings and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package melody_pkg;

    // ROM entry layout: {note[5:0], dur[3:0]}
    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 4;
    localparam int ENTRY_W    = NOTE_W + DUR_W;
    localparam int ROM_ADDR_W = 6;
    localparam int SONG_W     = 2;

    // Note indices understood by the buzzer (0 = rest)
    localparam logic [NOTE_W-1:0] REST   = 6'd0;
    localparam logic [NOTE_W-1:0] C_LOW  = 6'd1;
    localparam logic [NOTE_W-1:0] D_LOW  = 6'd2;
    localparam logic [NOTE_W-1:0] E_LOW  = 6'd3;
    localparam logic [NOTE_W-1:0] F_LOW  = 6'd4;
    localparam logic [NOTE_W-1:0] G_LOW  = 6'd5;
    localparam logic [NOTE_W-1:0] A_LOW  = 6'd6;
    localparam logic [NOTE_W-1:0] B_LOW  = 6'd7;
    localparam logic [NOTE_W-1:0] C_MID  = 6'd8;
    localparam logic [NOTE_W-1:0] D_MID  = 6'd9;
    localparam logic [NOTE_W-1:0] E_MID  = 6'd10;
    localparam logic [NOTE_W-1:0] F_MID  = 6'd11;
    localparam logic [NOTE_W-1:0] G_MID  = 6'd12;
    localparam logic [NOTE_W-1:0] A_MID  = 6'd13;
    localparam logic [NOTE_W-1:0] B_MID  = 6'd14;
    localparam logic [NOTE_W-1:0] C_HIGH = 6'd15;
    localparam logic [NOTE_W-1:0] D_HIGH = 6'd16;
    localparam logic [NOTE_W-1:0] E_HIGH = 6'd17;
    localparam logic [NOTE_W-1:0] F_HIGH = 6'd18;
    localparam logic [NOTE_W-1:0] G_HIGH = 6'd19;
    localparam logic [NOTE_W-1:0] A_HIGH = 6'd20;
    localparam logic [NOTE_W-1:0] B_HIGH = 6'd21;

    // Song ids
    localparam logic [SONG_W-1:0] SONG_BGM      = 2'd0;
    localparam logic [SONG_W-1:0] SONG_GAMEOVER = 2'd1;
    localparam logic [SONG_W-1:0] SONG_START    = 2'd2;
    localparam logic [SONG_W-1:0] SONG_PERFECT  = 2'd3;

    // Base address of each song, indexed by song id
    localparam logic [3:0][ROM_ADDR_W-1:0] SONG_BASE = {6'd60, 6'd32, 6'd16, 6'd0};

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NEXT = 2'd1;
    localparam logic [1:0] ST_NOTE = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    function automatic rom_entry_t mk_entry(input logic [NOTE_W-1:0] note,
                                            input logic [DUR_W-1:0]  dur);
        rom_entry_t e;
        e.note = note;
        e.dur  = dur;
        return e;
    endfunction

    // Out-of-range note indices are silenced rather than passed to the buzzer
    function automatic logic [NOTE_W-1:0] note_clamp(input logic [NOTE_W-1:0] note);
        return (note > B_HIGH) ? REST : note;
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_rom.sv
`default_nettype none
// ============================================================================
//  Module      : melody_rom
//  Description : Combinational case-ROM holding all songs. Each entry is
//                {note[5:0], dur[3:0]}; dur = 0 terminates a song.
//  Ports       : i_addr  - entry address
//                o_entry - 10-bit entry at i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_rom
    import melody_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_entry
);

    always_comb begin
        o_entry = mk_entry(REST, 4'd0);
        case (int'(i_addr))
            // BGM (loops)
            0:  o_entry = mk_entry(C_MID,  4'd1);
            1:  o_entry = mk_entry(E_MID,  4'd1);
            2:  o_entry = mk_entry(REST,   4'd1);
            3:  o_entry = mk_entry(G_MID,  4'd2);
            4:  o_entry = mk_entry(REST,   4'd0);
            // GAMEOVER
            16: o_entry = mk_entry(G_MID,  4'd2);
            17: o_entry = mk_entry(E_MID,  4'd2);
            18: o_entry = mk_entry(C_MID,  4'd4);
            19: o_entry = mk_entry(REST,   4'd0);
            // START
            32: o_entry = mk_entry(C_HIGH, 4'd1);
            33: o_entry = mk_entry(G_MID,  4'd1);
            34: o_entry = mk_entry(C_HIGH, 4'd2);
            35: o_entry = mk_entry(REST,   4'd0);
            // PERFECT
            60: o_entry = mk_entry(C_MID,  4'd2);
            61: o_entry = mk_entry(G_MID,  4'd1);
            62: o_entry = mk_entry(REST,   4'd0);
            default: o_entry = mk_entry(REST, 4'd0);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Steps through the melody ROM at the tempo tick rate and
//                drives the note index consumed by the buzzer. Supports one
//                looping background track and one-shot jingles.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_req, i_req_song - start-song pulse and song id
//                i_stop            - abort-playback pulse
//                music_scale       - registered note index (0 = silence)
//                o_busy            - a song is playing
//                o_song            - id of current/last song
//                o_song_done       - one-shot song ended naturally (pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 8,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [SONG_W-1:0] i_req_song,
    input  logic              i_stop,
    output logic [NOTE_W-1:0] music_scale,
    output logic              o_busy,
    output logic [SONG_W-1:0] o_song,
    output logic              o_song_done
);

    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int CYC_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(TICK_CYC - 1);
    // Last sounded cycle inside the final tick of an entry
    localparam logic [CYC_W-1:0] c_note_last = CYC_W'(TICK_CYC - GAP_CYCLES - 1);
    localparam logic [DUR_W-1:0] c_dur_one   = DUR_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [CYC_W-1:0]  cyc_q,         cyc_d;
    logic [DUR_W-1:0]  tick_q,        tick_d;
    logic [NOTE_W-1:0] note_q,        note_d;
    logic [DUR_W-1:0]  dur_q,         dur_d;
    logic [SONG_W-1:0] song_q,        song_d;
    logic [NOTE_W-1:0] music_scale_q, music_scale_d;
    logic              busy_q,        busy_d;
    logic              done_q,        done_d;

    logic [ENTRY_W-1:0] w_entry_raw;
    rom_entry_t         w_entry;
    logic               w_tick_last;
    logic               w_last_tick;
    logic               w_entry_end;
    logic               w_gap_start;
    logic               w_done_evt;

    // The address register always points at the entry to be loaded next, so
    // the following entry is already visible when the current one ends and
    // playback continues without an idle cycle.
    melody_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .i_addr  (addr_q),
        .o_entry (w_entry_raw)
    );

    assign w_entry     = rom_entry_t'(w_entry_raw);
    assign w_tick_last = (cyc_q == c_cyc_last);
    assign w_last_tick = (tick_q == (dur_q - c_dur_one));
    assign w_entry_end = w_tick_last && w_last_tick;
    assign w_gap_start = (cyc_q == c_note_last) && w_last_tick;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            cyc_q         <= '0;
            tick_q        <= '0;
            note_q        <= '0;
            dur_q         <= '0;
            song_q        <= '0;
            music_scale_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cyc_q         <= cyc_d;
            tick_q        <= tick_d;
            note_q        <= note_d;
            dur_q         <= dur_d;
            song_q        <= song_d;
            music_scale_q <= music_scale_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        tick_d     = tick_q;
        note_d     = note_q;
        dur_d      = dur_q;
        song_d     = song_q;
        w_done_evt = 1'b0;

        if (i_req) begin
            // Requests preempt everything, including a stop and an end marker
            state_d = ST_NEXT;
            addr_d  = ADDR_W'(SONG_BASE[i_req_song]);
            cyc_d   = '0;
            tick_d  = '0;
            song_d  = i_req_song;
        end else if (i_stop) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_NEXT: begin
                    // Song start: the first entry is never an end marker
                    state_d = ST_NOTE;
                    note_d  = note_clamp(w_entry.note);
                    dur_d   = w_entry.dur;
                    addr_d  = addr_q + ADDR_W'(1);
                    cyc_d   = '0;
                    tick_d  = '0;
                end
                ST_NOTE, ST_GAP: begin
                    if (w_entry_end) begin
                        cyc_d  = '0;
                        tick_d = '0;
                        if (w_entry.dur == '0) begin
                            if (song_q == SONG_BGM) begin
                                state_d = ST_NEXT;
                                addr_d  = ADDR_W'(SONG_BASE[SONG_BGM]);
                            end else begin
                                state_d    = ST_IDLE;
                                w_done_evt = 1'b1;
                            end
                        end else begin
                            state_d = ST_NOTE;
                            note_d  = note_clamp(w_entry.note);
                            dur_d   = w_entry.dur;
                            addr_d  = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        if (w_tick_last) begin
                            cyc_d  = '0;
                            tick_d = tick_q + c_dur_one;
                        end else begin
                            cyc_d  = cyc_q + CYC_W'(1);
                        end
                        if ((state_q == ST_NOTE) && w_gap_start) begin
                            state_d = ST_GAP;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: outputs are registered from the next state so they
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        music_scale_d = (state_d == ST_NOTE) ? note_d : REST;
        busy_d        = (state_d != ST_IDLE);
        done_d        = w_done_evt;
    end

    assign music_scale = music_scale_q;
    assign o_busy      = busy_q;
    assign o_song      = song_q;
    assign o_song_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_sequencer
//  Description : Directed self-checking bench for melody_sequencer with
//                CLK_HZ=100, TICK_HZ=10 (TICK_CYC=10), GAP_CYCLES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       i_req      = 1'b0;
    logic [1:0] i_req_song = 2'd0;
    logic       i_stop     = 1'b0;
    logic [5:0] music_scale;
    logic       o_busy;
    logic [1:0] o_song;
    logic       o_song_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench copy of the BGM table
    int bgm_note [4] = '{8, 10, 0, 12};
    int bgm_dur  [4] = '{1, 1, 1, 2};

    melody_sequencer #(
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .GAP_CYCLES (2),
        .ADDR_W     (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_req_song  (i_req_song),
        .i_stop      (i_stop),
        .music_scale (music_scale),
        .o_busy      (o_busy),
        .o_song      (o_song),
        .o_song_done (o_song_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse i_req; returns just after the sampling edge (edge 0)
    task automatic req_song(input logic [1:0] id);
        i_req      = 1'b1;
        i_req_song = id;
        tick();
        i_req      = 1'b0;
    endtask

    // PERFECT: note 8 for 18 clocks, gap 2, note 12 for 8 clocks, gap 2, done
    task automatic expect_perfect(input string name);
        for (int e = 1; e <= 31; e++) begin
            int exp_ms;
            tick();
            if (e <= 18)      exp_ms = 8;
            else if (e <= 20) exp_ms = 0;
            else if (e <= 28) exp_ms = 12;
            else              exp_ms = 0;
            check($sformatf("%s ms e%0d", name, e), music_scale, exp_ms);
            check($sformatf("%s busy e%0d", name, e), o_busy, (e <= 30) ? 1 : 0);
            check($sformatf("%s done e%0d", name, e), o_song_done, (e == 31) ? 1 : 0);
        end
        check($sformatf("%s song", name), o_song, 3);
        tick();
        check($sformatf("%s done once", name), o_song_done, 0);
        check($sformatf("%s idle busy", name), o_busy, 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst ms", music_scale, 0);
            check("rst busy", o_busy, 0);
            check("rst done", o_song_done, 0);
            check("rst song", o_song, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle ms", music_scale, 0);
            check("idle busy", o_busy, 0);
            check("idle done", o_song_done, 0);
        end

        // ---------------- PERFECT one-shot ----------------
        req_song(2'd3);
        expect_perfect("perfect");

        // ---------------- BGM loops ----------------
        req_song(2'd0);
        for (int lp = 0; lp < 3; lp++) begin
            for (int en = 0; en < 4; en++) begin
                for (int c = 0; c < bgm_dur[en] * 10; c++) begin
                    int exp_ms;
                    tick();
                    exp_ms = (bgm_note[en] != 0 && c < bgm_dur[en] * 10 - 2) ? bgm_note[en] : 0;
                    check($sformatf("bgm ms l%0d e%0d c%0d", lp, en, c), music_scale, exp_ms);
                    check("bgm busy", o_busy, 1);
                    check("bgm done", o_song_done, 0);
                end
            end
            tick();
            check($sformatf("bgm marker ms l%0d", lp), music_scale, 0);
            check("bgm marker busy", o_busy, 1);
            check("bgm marker done", o_song_done, 0);
        end
        tick();
        check("bgm loop restart ms", music_scale, 8);
        check("bgm song", o_song, 0);

        // ---------------- preempt BGM with PERFECT at edge 5 ----------------
        req_song(2'd0);
        for (int i = 0; i < 4; i++) tick();
        check("preempt bgm ms e4", music_scale, 8);
        req_song(2'd3);
        check("preempt song", o_song, 3);
        expect_perfect("preempt");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("no bgm resume ms", music_scale, 0);
            check("no bgm resume busy", o_busy, 0);
        end

        // ---------------- stop GAMEOVER ----------------
        req_song(2'd1);
        for (int i = 0; i < 10; i++) tick();
        check("gameover ms e10", music_scale, 12);
        check("gameover song", o_song, 1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stop ms", music_scale, 0);
        check("stop busy", o_busy, 0);
        check("stop done", o_song_done, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("after stop done", o_song_done, 0);
            check("after stop busy", o_busy, 0);
        end

        // ---------------- stop and request together ----------------
        req_song(2'd1);
        for (int i = 0; i < 3; i++) tick();
        i_stop     = 1'b1;
        i_req      = 1'b1;
        i_req_song = 2'd2;
        tick();
        i_stop = 1'b0;
        i_req  = 1'b0;
        check("req beats stop busy", o_busy, 1);
        check("req beats stop song", o_song, 2);
        tick();
        check("start first note", music_scale, 15);

        // ---------------- reset mid-song ----------------
        req_song(2'd3);
        for (int i = 0; i < 15; i++) tick();
        check("pre-rst ms", music_scale, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst ms", music_scale, 0);
        check("mid rst busy", o_busy, 0);
        check("mid rst done", o_song_done, 0);
        check("mid rst song", o_song, 0);
        req_song(2'd3);
        expect_perfect("after rst");

        // ---------------- request on the end-marker cycle ----------------
        req_song(2'd3);
        for (int i = 0; i < 30; i++) tick();
        check("marker edge30 ms", music_scale, 0);
        check("marker edge30 busy", o_busy, 1);
        req_song(2'd2);
        check("req at marker no done", o_song_done, 0);
        check("req at marker busy", o_busy, 1);
        check("req at marker song", o_song, 2);
        tick();
        check("req at marker new note", music_scale, 15);
        check("req at marker still no done", o_song_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
